// File: rtl/inpass_cfg_loader.sv
// Configuration loader for the input-pass BELs: assembles valid/ready frames into a
// shadow register and commits it atomically to ConfigBits (0 = combinational, 1 = registered).
//
// state  | meaning
// IDLE   | waiting for frame 0; cfg_clear zeroes the active configuration
// LOAD   | collecting frames 1..NFRAMES-1
// DRAIN  | overlong configuration, discarding beats until in_last
// COMMIT | one cycle; shadow is copied to ConfigBits at the exit edge
module inpass_cfg_loader #(
   parameter int NUM_BELS     = 4,
   parameter int BITS_PER_BEL = 4,
   parameter int FRAME_WIDTH  = 8
) (
   input  logic                             UserCLK,
   input  logic                             RESETn,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [FRAME_WIDTH-1:0]           in_data,
   input  logic                             in_last,
   input  logic                             cfg_clear,
   output logic [NUM_BELS*BITS_PER_BEL-1:0] ConfigBits,
   output logic                             cfg_busy,
   output logic                             cfg_done,
   output logic                             cfg_err
);

   localparam int TOTAL   = NUM_BELS * BITS_PER_BEL;
   localparam int NFRAMES = (TOTAL + FRAME_WIDTH - 1) / FRAME_WIDTH;
   localparam int CNT_W   = (NFRAMES < 2) ? 1 : $clog2(NFRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NFRAMES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, COMMIT} state_t;

   state_t                           state, stateNext;
   logic [CNT_W-1:0]                 cnt, cntNext;
   logic [NFRAMES*FRAME_WIDTH-1:0]   shadow;
   logic                             beatAcc, wrShadow, errNext;

   assign in_ready = (state == LOAD) || (state == DRAIN) || ((state == IDLE) && !cfg_clear);
   assign beatAcc  = in_valid && in_ready;
   assign cfg_busy = (state != IDLE);

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      wrShadow  = 1'b0;
      errNext   = 1'b0;
      unique case (state)
         IDLE: begin
            if (beatAcc) begin
               wrShadow = 1'b1;
               cntNext  = CNT_ONE;
               if (in_last) begin
                  if (NFRAMES == 1) begin
                     stateNext = COMMIT;
                  end else begin
                     errNext = 1'b1;
                     cntNext = '0;
                  end
               end else begin
                  stateNext = (NFRAMES == 1) ? DRAIN : LOAD;
               end
            end
         end
         LOAD: begin
            if (beatAcc) begin
               wrShadow = 1'b1;
               cntNext  = cnt + CNT_ONE;
               if (cnt == LAST_IDX) begin
                  stateNext = in_last ? COMMIT : DRAIN;
               end else if (in_last) begin
                  errNext   = 1'b1;
                  stateNext = IDLE;
                  cntNext   = '0;
               end
            end
         end
         DRAIN: begin
            if (beatAcc && in_last) begin
               errNext   = 1'b1;
               stateNext = IDLE;
               cntNext   = '0;
            end
         end
         COMMIT: begin
            stateNext = IDLE;
            cntNext   = '0;
         end
         default: begin
            stateNext = IDLE;
            cntNext   = '0;
         end
      endcase
   end

   always_ff @(posedge UserCLK or negedge RESETn) begin
      if (!RESETn) begin
         state      <= IDLE;
         cnt        <= '0;
         shadow     <= '0;
         ConfigBits <= '0;
         cfg_done   <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         state    <= stateNext;
         cnt      <= cntNext;
         cfg_done <= (state == COMMIT);
         cfg_err  <= errNext;
         for (int f = 0; f < NFRAMES; f++) begin
            if (wrShadow && (cnt == CNT_W'(f)))
               shadow[f*FRAME_WIDTH +: FRAME_WIDTH] <= in_data;
         end
         // Only a commit or an idle clear may touch the active configuration.
         if (state == COMMIT)
            ConfigBits <= shadow[TOTAL-1:0];
         else if ((state == IDLE) && cfg_clear)
            ConfigBits <= '0;
      end
   end

endmodule

// File: tb/tb_inpass_cfg_loader.sv
// Directed bench for inpass_cfg_loader: vector table for the per-cycle behaviour,
// hand sequences for gapped streams, clear during load and mid-cycle reset.
module tb_inpass_cfg_loader;

   logic        UserCLK = 1'b0;
   logic        RESETn  = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = 8'h00;
   logic        in_last = 1'b0;
   logic        cfg_clear = 1'b0;
   logic [15:0] ConfigBits;
   logic        cfg_busy, cfg_done, cfg_err;

   int checks = 0;
   int errors = 0;
   int doneCnt = 0;

   inpass_cfg_loader #(.NUM_BELS(4), .BITS_PER_BEL(4), .FRAME_WIDTH(8)) dut (
      .UserCLK(UserCLK), .RESETn(RESETn), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .cfg_clear(cfg_clear), .ConfigBits(ConfigBits),
      .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
   );

   always #5 UserCLK = ~UserCLK;

   typedef struct {
      logic        vld;
      logic [7:0]  dat;
      logic        lst;
      logic        clr;
      logic        expRdy;
      logic        expBusy;
      logic [15:0] expCfg;
      logic        expDone;
      logic        expErr;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge UserCLK);
      #1;
      if (cfg_done) doneCnt++;
   endtask

   task automatic idleIn();
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_data   = 8'h00;
      cfg_clear = 1'b0;
   endtask

   task automatic sendBeat(input logic [7:0] d, input logic l, input int gap);
      int w;
      idleIn();
      repeat (gap) tick();
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      w = 0;
      while (!in_ready && w < 20) begin
         tick();
         w++;
      end
      chk("beat_ready", {31'd0, in_ready}, 32'd1);
      tick();
      idleIn();
   endtask

   initial begin
      vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3CA5, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3CA5, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 16'h3CA5, 1'b0, 1'b1};
      vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3CA5, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 16'h3CA5, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 16'h3CA5, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 16'h3CA5, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3CA5, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 16'h3CA5, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 16'h3CA5, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00FF, 1'b1, 1'b0};
      vecs[13] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};

      repeat (2) @(posedge UserCLK);
      #1;
      chk("rst_cfg",  {16'd0, ConfigBits}, 32'h0);
      chk("rst_busy", {31'd0, cfg_busy}, 32'd0);
      chk("rst_done", {31'd0, cfg_done}, 32'd0);
      chk("rst_err",  {31'd0, cfg_err}, 32'd0);
      @(negedge UserCLK);
      RESETn = 1'b1;
      @(posedge UserCLK);
      #1;

      for (int i = 0; i < 15; i++) begin
         in_valid  = vecs[i].vld;
         in_data   = vecs[i].dat;
         in_last   = vecs[i].lst;
         cfg_clear = vecs[i].clr;
         #1;
         chk($sformatf("v%0d_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].expRdy});
         @(posedge UserCLK);
         #1;
         chk($sformatf("v%0d_cfg", i),  {16'd0, ConfigBits}, {16'd0, vecs[i].expCfg});
         chk($sformatf("v%0d_busy", i), {31'd0, cfg_busy}, {31'd0, vecs[i].expBusy});
         chk($sformatf("v%0d_done", i), {31'd0, cfg_done}, {31'd0, vecs[i].expDone});
         chk($sformatf("v%0d_err", i),  {31'd0, cfg_err}, {31'd0, vecs[i].expErr});
      end
      idleIn();

      // Gapped stream; exactly one commit pulse expected.
      doneCnt = 0;
      sendBeat(8'hFF, 1'b0, $urandom_range(3, 0));
      sendBeat(8'h00, 1'b1, $urandom_range(3, 0));
      repeat (4) tick();
      chk("gap_cfg",  {16'd0, ConfigBits}, 32'h00FF);
      chk("gap_done", doneCnt, 32'd1);

      // Clear while loading is ignored.
      sendBeat(8'h12, 1'b0, 0);
      cfg_clear = 1'b1;
      tick();
      cfg_clear = 1'b0;
      chk("clrload_cfg",  {16'd0, ConfigBits}, 32'h00FF);
      chk("clrload_busy", {31'd0, cfg_busy}, 32'd1);
      doneCnt = 0;
      sendBeat(8'h34, 1'b1, 0);
      tick();
      chk("clrload_commit", {16'd0, ConfigBits}, 32'h3412);
      chk("clrload_done",   doneCnt, 32'd1);

      // Asynchronous reset in the middle of a load.
      sendBeat(8'hAB, 1'b0, 0);
      chk("prerst_busy", {31'd0, cfg_busy}, 32'd1);
      #2;
      RESETn = 1'b0;
      #1;
      chk("arst_cfg",  {16'd0, ConfigBits}, 32'h0);
      chk("arst_busy", {31'd0, cfg_busy}, 32'd0);
      chk("arst_done", {31'd0, cfg_done}, 32'd0);
      chk("arst_err",  {31'd0, cfg_err}, 32'd0);
      @(negedge UserCLK);
      RESETn = 1'b1;
      @(posedge UserCLK);
      #1;
      doneCnt = 0;
      sendBeat(8'h5A, 1'b0, 0);
      sendBeat(8'hC3, 1'b1, 0);
      chk("post_rst_pre", {16'd0, ConfigBits}, 32'h0);
      tick();
      chk("post_rst_cfg",  {16'd0, ConfigBits}, 32'hC35A);
      chk("post_rst_done", doneCnt, 32'd1);
      tick();
      chk("post_rst_pulse", {31'd0, cfg_done}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
